// File: rtl/zap_tlb_walk_ctrl.sv
// zap_tlb_walk_ctrl: page-table walk sequencer for the ZAP MMU.
// On a TLB miss it fetches the L1 descriptor, and the L2 descriptor when the
// L1 entry points at a page table, over a single-outstanding read-only bus.
// Every walk ends in DONE with either a one-cycle refill strobe or a one-cycle
// fault strobe. A flush cancels the walk silently, but an access already on
// the bus is always allowed to complete first.
// Optional build macro ZAP_TLB_WALK_TIMEOUT_EN: aborts a fetch that waits
// TIMEOUT_CYCLES cycles without ack/err and reports it as an external abort.
//
// state  | meaning
// IDLE   | waiting for a walk request
// L1_REQ | L1 descriptor fetch on the bus
// L1_DEC | decode L1 type: section refill, fault, or start an L2 fetch
// L2_REQ | L2 descriptor fetch on the bus
// L2_DEC | decode L2 type: page refill or fault
// DONE   | pulse refill or fault strobe, then return to IDLE
module zap_tlb_walk_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_walk,
    input  logic [31:0] i_va,
    input  logic [31:0] i_baddr,
    input  logic        i_flush,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic [31:0] o_wb_adr,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    input  logic [31:0] i_wb_dat,
    output logic        o_busy,
    output logic        o_tlb_we,
    output logic [3:0]  o_tlb_sel,
    output logic [31:0] o_tlb_va,
    output logic [31:0] o_tlb_l1,
    output logic [31:0] o_tlb_l2,
    output logic        o_fault,
    output logic [7:0]  o_fsr,
    output logic [31:0] o_far
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        L1_REQ = 3'd1,
        L1_DEC = 3'd2,
        L2_REQ = 3'd3,
        L2_DEC = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] va_q, va_d, l1_q, l1_d, l2_q, l2_d, adr_q, adr_d;
    logic        flush_q, flush_d, fault_q, fault_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] tlb_va_q, tlb_va_d, tlb_l1_q, tlb_l1_d, tlb_l2_q, tlb_l2_d;
    logic [7:0]  fsr_q, fsr_d;
    logic [31:0] far_q, far_d;

    logic        req_active, flush_now, timeout;
    logic        go_fault, go_refill;
    logic [7:0]  f_code;
    logic [3:0]  r_sel;
    logic [31:0] r_l2;

    assign req_active = (state_q == L1_REQ) || (state_q == L2_REQ);
    assign flush_now  = flush_q || i_flush;

`ifdef ZAP_TLB_WALK_TIMEOUT_EN
    logic [8:0] wait_cnt_q, wait_cnt_d;

    // Wait counter runs while a strobe is outstanding; every other state clears it.
    always_comb wait_cnt_d = req_active ? wait_cnt_q + 9'd1 : 9'd0;

    // Wait counter register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) wait_cnt_q <= 9'd0;
        else         wait_cnt_q <= wait_cnt_d;
    end

    assign timeout = req_active && (wait_cnt_q == 9'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // Table base is 16 KB aligned; low bits never reach the address.
    logic unused_baddr_lo;
    assign unused_baddr_lo = ^i_baddr[13:0];

    // Next-state, descriptor capture and walk-result selection.
    always_comb begin
        state_d   = state_q;
        va_d      = va_q;
        l1_d      = l1_q;
        l2_d      = l2_q;
        adr_d     = adr_q;
        flush_d   = (state_q == IDLE) ? 1'b0 : flush_now;
        fault_d   = fault_q;
        sel_d     = sel_q;
        tlb_va_d  = tlb_va_q;
        tlb_l1_d  = tlb_l1_q;
        tlb_l2_d  = tlb_l2_q;
        fsr_d     = fsr_q;
        far_d     = far_q;
        go_fault  = 1'b0;
        go_refill = 1'b0;
        f_code    = 8'h00;
        r_sel     = 4'b0000;
        r_l2      = 32'h0;

        case (state_q)
            IDLE: begin
                if (!i_flush && i_walk) begin
                    va_d    = i_va;
                    adr_d   = {i_baddr[31:14], i_va[31:20], 2'b00};
                    state_d = L1_REQ;
                end
            end
            L1_REQ: begin
                if (i_wb_err || (!i_wb_ack && timeout)) begin
                    if (flush_now) state_d = IDLE;
                    else begin
                        go_fault = 1'b1;
                        f_code   = 8'h0C;
                    end
                end else if (i_wb_ack) begin
                    l1_d    = i_wb_dat;
                    state_d = flush_now ? IDLE : L1_DEC;
                end
            end
            L1_DEC: begin
                if (i_flush) state_d = IDLE;
                else begin
                    case (l1_q[1:0])
                        2'b00: begin
                            go_fault = 1'b1;
                            f_code   = 8'h05;
                        end
                        2'b10: begin
                            go_refill = 1'b1;
                            r_sel     = 4'b0001;
                        end
                        2'b01: begin
                            adr_d   = {l1_q[31:10], va_q[19:12], 2'b00};
                            state_d = L2_REQ;
                        end
                        default: begin
                            adr_d   = {l1_q[31:12], va_q[19:10], 2'b00};
                            state_d = L2_REQ;
                        end
                    endcase
                end
            end
            L2_REQ: begin
                if (i_wb_err || (!i_wb_ack && timeout)) begin
                    if (flush_now) state_d = IDLE;
                    else begin
                        go_fault = 1'b1;
                        f_code   = {l1_q[8:5], 4'hE};
                    end
                end else if (i_wb_ack) begin
                    l2_d    = i_wb_dat;
                    state_d = flush_now ? IDLE : L2_DEC;
                end
            end
            L2_DEC: begin
                if (i_flush) state_d = IDLE;
                else begin
                    r_l2 = l2_q;
                    case (l2_q[1:0])
                        2'b01: begin
                            go_refill = 1'b1;
                            r_sel     = 4'b0010;
                        end
                        2'b10: begin
                            go_refill = 1'b1;
                            r_sel     = 4'b0100;
                        end
                        2'b11: begin
                            // Tiny pages only exist under a fine page table.
                            if (l1_q[1:0] == 2'b11) begin
                                go_refill = 1'b1;
                                r_sel     = 4'b1000;
                            end else begin
                                go_fault = 1'b1;
                                f_code   = {l1_q[8:5], 4'h7};
                            end
                        end
                        default: begin
                            go_fault = 1'b1;
                            f_code   = {l1_q[8:5], 4'h7};
                        end
                    endcase
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (go_fault) begin
            state_d = DONE;
            fault_d = 1'b1;
            fsr_d   = f_code;
            far_d   = va_q;
        end
        if (go_refill) begin
            state_d  = DONE;
            fault_d  = 1'b0;
            sel_d    = r_sel;
            tlb_va_d = va_q;
            tlb_l1_d = l1_q;
            tlb_l2_d = r_l2;
        end
    end

    // State, captured walk context and held result registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= IDLE;
            va_q     <= 32'h0;
            l1_q     <= 32'h0;
            l2_q     <= 32'h0;
            adr_q    <= 32'h0;
            flush_q  <= 1'b0;
            fault_q  <= 1'b0;
            sel_q    <= 4'b0000;
            tlb_va_q <= 32'h0;
            tlb_l1_q <= 32'h0;
            tlb_l2_q <= 32'h0;
            fsr_q    <= 8'h00;
            far_q    <= 32'h0;
        end else begin
            state_q  <= state_d;
            va_q     <= va_d;
            l1_q     <= l1_d;
            l2_q     <= l2_d;
            adr_q    <= adr_d;
            flush_q  <= flush_d;
            fault_q  <= fault_d;
            sel_q    <= sel_d;
            tlb_va_q <= tlb_va_d;
            tlb_l1_q <= tlb_l1_d;
            tlb_l2_q <= tlb_l2_d;
            fsr_q    <= fsr_d;
            far_q    <= far_d;
        end
    end

    assign o_wb_cyc  = req_active;
    assign o_wb_stb  = req_active;
    assign o_wb_adr  = adr_q;
    assign o_busy    = (state_q != IDLE);
    assign o_tlb_we  = (state_q == DONE) && !fault_q;
    assign o_fault   = (state_q == DONE) && fault_q;
    assign o_tlb_sel = sel_q;
    assign o_tlb_va  = tlb_va_q;
    assign o_tlb_l1  = tlb_l1_q;
    assign o_tlb_l2  = tlb_l2_q;
    assign o_fsr     = fsr_q;
    assign o_far     = far_q;

endmodule

// File: tb/tb_zap_tlb_walk_ctrl.sv
// Testbench for zap_tlb_walk_ctrl: table of directed walks, randomized walks
// against a behavioural model, and hand sequences for flush, reset and timeout.
module tb_zap_tlb_walk_ctrl;
    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_walk;
    logic [31:0] i_va;
    logic [31:0] i_baddr;
    logic        i_flush;
    logic        o_wb_cyc, o_wb_stb;
    logic [31:0] o_wb_adr;
    logic        i_wb_ack, i_wb_err;
    logic [31:0] i_wb_dat;
    logic        o_busy, o_tlb_we, o_fault;
    logic [3:0]  o_tlb_sel;
    logic [31:0] o_tlb_va, o_tlb_l1, o_tlb_l2, o_far;
    logic [7:0]  o_fsr;

`ifdef ZAP_TLB_WALK_TIMEOUT_EN
    zap_tlb_walk_ctrl #(.TIMEOUT_CYCLES(8)) dut (
`else
    zap_tlb_walk_ctrl dut (
`endif
        .i_clk(i_clk), .i_reset(i_reset), .i_walk(i_walk), .i_va(i_va),
        .i_baddr(i_baddr), .i_flush(i_flush), .o_wb_cyc(o_wb_cyc),
        .o_wb_stb(o_wb_stb), .o_wb_adr(o_wb_adr), .i_wb_ack(i_wb_ack),
        .i_wb_err(i_wb_err), .i_wb_dat(i_wb_dat), .o_busy(o_busy),
        .o_tlb_we(o_tlb_we), .o_tlb_sel(o_tlb_sel), .o_tlb_va(o_tlb_va),
        .o_tlb_l1(o_tlb_l1), .o_tlb_l2(o_tlb_l2), .o_fault(o_fault),
        .o_fsr(o_fsr), .o_far(o_far)
    );

    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] va, baddr, l1, l2;
        int          w1, w2;
        bit          e1, e2, both;
        bit          x_fault;
        logic [3:0]  x_sel;
        logic [7:0]  x_fsr;
        logic [31:0] x_l2adr;
        int          x_cyc;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] l1_addr(input logic [31:0] va, input logic [31:0] baddr);
        return (baddr & 32'hFFFF_C000) | ((va >> 20) << 2);
    endfunction

    // Outcome of a walk derived from the descriptor rules and bus latencies.
    function automatic vec_t model(input vec_t v);
        vec_t        r;
        logic [3:0]  dom;
        int          t1, t2;
        r = v;
        dom = 4'((v.l1 >> 5) & 32'hF);
        t1 = int'(v.l1 & 32'h3);
        t2 = int'(v.l2 & 32'h3);
        r.x_fault = 1'b0; r.x_sel = 4'd0; r.x_fsr = 8'd0; r.x_l2adr = 32'd0;
        if (v.e1) begin
            r.x_fault = 1'b1; r.x_fsr = 8'h0C; r.x_cyc = 2 + v.w1;
        end else if (t1 == 0) begin
            r.x_fault = 1'b1; r.x_fsr = 8'h05; r.x_cyc = 3 + v.w1;
        end else if (t1 == 2) begin
            r.x_sel = 4'd1; r.x_cyc = 3 + v.w1;
        end else begin
            if (t1 == 1) r.x_l2adr = (v.l1 & 32'hFFFF_FC00) | (((v.va >> 12) & 32'hFF) << 2);
            else         r.x_l2adr = (v.l1 & 32'hFFFF_F000) | (((v.va >> 10) & 32'h3FF) << 2);
            if (v.e2) begin
                r.x_fault = 1'b1; r.x_fsr = {dom, 4'hE}; r.x_cyc = 4 + v.w1 + v.w2;
            end else begin
                r.x_cyc = 5 + v.w1 + v.w2;
                if (t2 == 1)                r.x_sel = 4'd2;
                else if (t2 == 2)           r.x_sel = 4'd4;
                else if (t2 == 3 && t1 == 3) r.x_sel = 4'd8;
                else begin r.x_fault = 1'b1; r.x_fsr = {dom, 4'h7}; end
            end
        end
        return r;
    endfunction

    // Called just after a negedge with the DUT idle; returns after the IDLE cycle following DONE.
    task automatic run_walk(input vec_t v, input string tag);
        int cyc, w, acc;
        bit done, first;
        i_walk = 1'b1; i_va = v.va; i_baddr = v.baddr;
        cyc = 0; acc = 0; w = v.w1; done = 1'b0; first = 1'b1;
        while (!done && cyc < 100) begin
            @(negedge i_clk);
            cyc++;
            i_walk = 1'b0; i_va = $urandom; i_baddr = $urandom;
            i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_dat = $urandom;
            if (o_wb_stb) begin
                chk({tag, " cyc_with_stb"}, 32'(o_wb_cyc), 32'd1);
                if (acc == 0) begin
                    chk({tag, " l1_adr"}, o_wb_adr, l1_addr(v.va, v.baddr));
                    if (first) chk({tag, " stb_cycle"}, 32'(cyc), 32'd1);
                    first = 1'b0;
                end else begin
                    chk({tag, " l2_adr"}, o_wb_adr, v.x_l2adr);
                end
                if (w > 0) w--;
                else begin
                    if ((acc == 0 && v.e1) || (acc == 1 && v.e2)) begin
                        i_wb_err = 1'b1; i_wb_ack = v.both;
                    end else begin
                        i_wb_ack = 1'b1; i_wb_dat = (acc == 0) ? v.l1 : v.l2;
                    end
                    acc++;
                    w = v.w2;
                end
            end
            if (o_tlb_we || o_fault) begin
                done = 1'b1;
                chk({tag, " done_cycle"}, 32'(cyc), 32'(v.x_cyc));
                chk({tag, " fault"}, 32'(o_fault), 32'(v.x_fault));
                chk({tag, " tlb_we"}, 32'(o_tlb_we), 32'(!v.x_fault));
                if (v.x_fault) begin
                    chk({tag, " fsr"}, 32'(o_fsr), 32'(v.x_fsr));
                    chk({tag, " far"}, o_far, v.va);
                end else begin
                    chk({tag, " sel"}, 32'(o_tlb_sel), 32'(v.x_sel));
                    chk({tag, " tlb_va"}, o_tlb_va, v.va);
                    chk({tag, " tlb_l1"}, o_tlb_l1, v.l1);
                    chk({tag, " tlb_l2"}, o_tlb_l2, (v.x_sel == 4'd1) ? 32'd0 : v.l2);
                end
            end
        end
        if (!done) chk({tag, " walk_end_seen"}, 32'd0, 32'd1);
        @(negedge i_clk);
        i_wb_ack = 1'b0; i_wb_err = 1'b0;
        chk({tag, " strobe_one_cycle"}, 32'(o_tlb_we | o_fault), 32'd0);
        chk({tag, " idle_after_done"}, 32'(o_busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // va, baddr, l1, l2, w1, w2, e1, e2, both, x_fault, x_sel, x_fsr, x_l2adr, x_cyc
        tbl[0]  = '{32'h1234_5678, 32'h0000_4000, 32'h1230_0C02, 32'h0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 8'h00, 32'h0, 3};
        tbl[1]  = '{32'h1234_5678, 32'h0000_4000, 32'h0008_0121, 32'hABCD_E00E, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 8'h00, 32'h0008_0114, 5};
        tbl[2]  = '{32'h1234_5678, 32'h0000_4000, 32'h0008_0121, 32'h0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 8'h97, 32'h0008_0114, 5};
        tbl[3]  = '{32'hABC5_6789, 32'h0000_8000, 32'h0010_0033, 32'h5555_0FF3, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 8'h00, 32'h0010_0564, 5};
        tbl[4]  = '{32'hABC5_6789, 32'h0000_8000, 32'h0010_0031, 32'h5555_0FF3, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 8'h17, 32'h0010_0158, 5};
        tbl[5]  = '{32'h1234_5678, 32'h0000_4000, 32'h1230_0C02, 32'h0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 8'h0C, 32'h0, 2};
        tbl[6]  = '{32'h8765_4321, 32'hFFFF_C000, 32'h1230_0C02, 32'h0, 1, 0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 8'h0C, 32'h0, 3};
        tbl[7]  = '{32'h1234_5678, 32'h0000_4000, 32'h0000_0FF0, 32'h0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 8'h05, 32'h0, 3};
        tbl[8]  = '{32'h1234_5678, 32'h0000_4000, 32'h0008_0121, 32'h1234_5001, 2, 3, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 8'h00, 32'h0008_0114, 10};
        tbl[9]  = '{32'h1234_5678, 32'h0000_4000, 32'h1230_0C02, 32'h0, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 8'h00, 32'h0, 6};
        tbl[10] = '{32'h1234_5678, 32'h0000_4000, 32'h0008_0121, 32'h0, 0, 1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 8'h9E, 32'h0008_0114, 5};
        tbl[11] = '{32'hABC5_6789, 32'h0000_8000, 32'h0010_01E3, 32'h0000_0002, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 8'h00, 32'h0010_0564, 5};

        i_reset = 1'b1; i_walk = 1'b0; i_va = 32'h0; i_baddr = 32'h0; i_flush = 1'b0;
        i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_dat = 32'h0;
        #1;
        chk("rst busy", 32'(o_busy), 32'd0);
        chk("rst cyc_stb", 32'({o_wb_cyc, o_wb_stb}), 32'd0);
        chk("rst adr", o_wb_adr, 32'd0);
        chk("rst we_fault", 32'({o_tlb_we, o_fault}), 32'd0);
        chk("rst sel", 32'(o_tlb_sel), 32'd0);
        chk("rst tlb_va", o_tlb_va, 32'd0);
        chk("rst tlb_l1", o_tlb_l1, 32'd0);
        chk("rst tlb_l2", o_tlb_l2, 32'd0);
        chk("rst fsr", 32'(o_fsr), 32'd0);
        chk("rst far", o_far, 32'd0);
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);

        for (int i = 0; i < 12; i++) run_walk(tbl[i], $sformatf("tbl%0d", i));

        // Refill values must survive a later faulting walk.
        run_walk(tbl[0], "hold_refill");
        run_walk(tbl[5], "hold_fault");
        chk("hold sel", 32'(o_tlb_sel), 32'd1);
        chk("hold tlb_l1", o_tlb_l1, 32'h1230_0C02);
        chk("hold tlb_va", o_tlb_va, 32'h1234_5678);

        // Flush during L2_REQ with ack delayed: bus cycle completes, walk is dropped.
        i_walk = 1'b1; i_va = 32'h1234_5678; i_baddr = 32'h0000_4000;
        @(negedge i_clk);
        i_walk = 1'b0;
        chk("fl2 l1_stb", 32'(o_wb_stb), 32'd1);
        i_wb_ack = 1'b1; i_wb_dat = 32'h0008_0121;
        @(negedge i_clk);
        i_wb_ack = 1'b0;
        @(negedge i_clk);
        chk("fl2 l2_stb", 32'(o_wb_stb), 32'd1);
        chk("fl2 l2_adr", o_wb_adr, 32'h0008_0114);
        i_flush = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            i_flush = 1'b0;
            chk("fl2 stb_held", 32'(o_wb_stb), 32'd1);
            chk("fl2 adr_stable", o_wb_adr, 32'h0008_0114);
            chk("fl2 no_strobe", 32'(o_tlb_we | o_fault), 32'd0);
            if (k == 3) begin i_wb_ack = 1'b1; i_wb_dat = 32'hABCD_E00E; end
        end
        @(negedge i_clk);
        i_wb_ack = 1'b0;
        chk("fl2 idle", 32'(o_busy), 32'd0);
        chk("fl2 stb_low", 32'(o_wb_stb), 32'd0);
        chk("fl2 no_strobe_end", 32'(o_tlb_we | o_fault), 32'd0);
        run_walk(tbl[1], "after_flush");

        // Flush and walk together in IDLE: walk dropped.
        i_walk = 1'b1; i_flush = 1'b1; i_va = 32'h1234_5678; i_baddr = 32'h0000_4000;
        @(negedge i_clk);
        i_walk = 1'b0; i_flush = 1'b0;
        chk("flidle busy", 32'(o_busy), 32'd0);
        chk("flidle stb", 32'(o_wb_stb), 32'd0);
        @(negedge i_clk);
        chk("flidle busy2", 32'(o_busy), 32'd0);

        // Flush in L1_DEC.
        i_walk = 1'b1;
        @(negedge i_clk);
        i_walk = 1'b0; i_wb_ack = 1'b1; i_wb_dat = 32'h0008_0121;
        @(negedge i_clk);
        i_wb_ack = 1'b0; i_flush = 1'b1;
        @(negedge i_clk);
        i_flush = 1'b0;
        chk("fldec busy", 32'(o_busy), 32'd0);
        chk("fldec stb", 32'(o_wb_stb), 32'd0);
        chk("fldec no_strobe", 32'(o_tlb_we | o_fault), 32'd0);
        run_walk(tbl[3], "after_fldec");

        // Asynchronous reset mid-walk drops the bus request immediately.
        i_walk = 1'b1; i_va = 32'h1234_5678; i_baddr = 32'h0000_4000;
        @(negedge i_clk);
        i_walk = 1'b0;
        chk("rstmid stb_before", 32'(o_wb_stb), 32'd1);
        #2 i_reset = 1'b1;
        #1;
        chk("rstmid stb", 32'(o_wb_stb), 32'd0);
        chk("rstmid cyc", 32'(o_wb_cyc), 32'd0);
        chk("rstmid busy", 32'(o_busy), 32'd0);
        chk("rstmid tlb_l1", o_tlb_l1, 32'd0);
        @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);

`ifdef ZAP_TLB_WALK_TIMEOUT_EN
        begin
            int stb_cnt, flt_cyc;
            bit we_seen;
            stb_cnt = 0; flt_cyc = -1; we_seen = 1'b0;
            i_walk = 1'b1; i_va = 32'h1234_5678; i_baddr = 32'h0000_4000;
            for (int c = 1; c <= 13; c++) begin
                @(negedge i_clk);
                i_walk = 1'b0; i_wb_ack = 1'b0;
                if (o_wb_stb) stb_cnt++;
                if (o_fault) begin flt_cyc = c; chk("to fsr", 32'(o_fsr), 32'h0C); end
                if (o_tlb_we) we_seen = 1'b1;
                if (c == 10) begin i_wb_ack = 1'b1; i_wb_dat = 32'h1230_0C02; end
            end
            chk("to stb_cycles", 32'(stb_cnt), 32'd8);
            chk("to fault_cycle", 32'(flt_cyc), 32'd9);
            chk("to no_refill", 32'(we_seen), 32'd0);
            chk("to idle", 32'(o_busy), 32'd0);
        end
`endif

        for (int n = 0; n < 150; n++) begin
            vec_t v;
            v.va = $urandom; v.baddr = $urandom; v.l1 = $urandom; v.l2 = $urandom;
            v.w1 = $urandom_range(0, 3); v.w2 = $urandom_range(0, 3);
            v.e1 = ($urandom_range(0, 7) == 0); v.e2 = ($urandom_range(0, 7) == 0);
            v.both = 1'($urandom_range(0, 1));
            v = model(v);
            run_walk(v, $sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
